// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init-sequencer states, mode-register layout.
// Define SDRAM_INIT_EMRS_EN to add the EMRS/TEMRD states.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;

  localparam int MR_W      = 13;
  localparam int MR_BL_LSB = 0;
  localparam int MR_BT_BIT = 3;
  localparam int MR_CL_LSB = 4;
  localparam int MR_WB_BIT = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_TRP,
    ST_AREF,
    ST_TRFC,
    ST_MRS,
    ST_TMRD,
`ifdef SDRAM_INIT_EMRS_EN
    ST_EMRS,
    ST_TEMRD,
`endif
    ST_DONE
  } init_state_e;

  function automatic logic [MR_W-1:0] mode_word(input logic wb, input logic [2:0] cl,
                                                input logic bt, input logic [2:0] bl);
    logic [MR_W-1:0] w;
    w                = '0;
    w[MR_BL_LSB+:3]  = bl;
    w[MR_BT_BIT]     = bt;
    w[MR_CL_LSB+:3]  = cl;
    w[MR_WB_BIT]     = wb;
    return w;
  endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module sdram_delay_cnt #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)         cnt_q <= RST_VAL;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_param.sv
// Parametrised SDRAM power-up / re-init sequencer with registered command outputs.
// Define SDRAM_INIT_EMRS_EN to issue an EXTENDED MODE REGISTER SET after the MRS.
module sdram_init_param
  import sdram_pkg::*;
#(
  parameter int unsigned WAIT_CLK    = 20000,
  parameter int unsigned TRP_CLK     = 2,
  parameter int unsigned TRFC_CLK    = 7,
  parameter int unsigned TMRD_CLK    = 3,
  parameter int unsigned AREF_NUM    = 8,
  parameter int unsigned CAS_LAT     = 3,
  parameter logic [2:0]  BURST_LEN   = 3'b111,
  parameter logic        BURST_TYPE  = 1'b0,
  parameter logic        WRITE_BURST = 1'b0,
  parameter logic [12:0] EMRS_VAL    = 13'h0000,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned BA_W        = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              reinit_req,
  output logic [3:0]        init_cmd,
  output logic [BA_W-1:0]   init_ba,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_end,
  output logic              reinit_ack
);

  localparam int unsigned DMAX = (WAIT_CLK > TRFC_CLK) ? WAIT_CLK : TRFC_CLK;
  localparam int unsigned CW   = $clog2(DMAX + 1);

  localparam logic [CW-1:0]     LD_TRP   = CW'(TRP_CLK - 1);
  localparam logic [CW-1:0]     LD_TRFC  = CW'(TRFC_CLK - 1);
  localparam logic [CW-1:0]     LD_TMRD  = CW'(TMRD_CLK - 1);
  localparam logic [ADDR_W-1:0] MRS_ADDR =
    ADDR_W'(mode_word(WRITE_BURST, 3'(CAS_LAT), BURST_TYPE, BURST_LEN));

  init_state_e       state_q;
  logic [3:0]        cmd_q;
  logic [BA_W-1:0]   ba_q;
  logic [ADDR_W-1:0] addr_q;
  logic              end_q, ack_q;
  logic [3:0]        aref_cnt_q;

  logic              dly_load, dly_done;
  logic [CW-1:0]     dly_val;

  // Every one-cycle command state is followed by a wait state, so the delay
  // is armed while the command is on the bus.
  always_comb begin
    dly_load = 1'b0;
    dly_val  = '0;
    case (state_q)
      ST_PRE:  begin dly_load = 1'b1; dly_val = LD_TRP;  end
      ST_AREF: begin dly_load = 1'b1; dly_val = LD_TRFC; end
      ST_MRS:  begin dly_load = 1'b1; dly_val = LD_TMRD; end
`ifdef SDRAM_INIT_EMRS_EN
      ST_EMRS: begin dly_load = 1'b1; dly_val = LD_TMRD; end
`endif
      default: ;
    endcase
  end

  // Reset preloads the full power-up wait so IDLE needs no separate load.
  sdram_delay_cnt #(.W(CW), .RST_VAL(CW'(WAIT_CLK))) u_dly (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .done_o     (dly_done)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_NOP;
      ba_q       <= '1;
      addr_q     <= '1;
      end_q      <= 1'b0;
      ack_q      <= 1'b0;
      aref_cnt_q <= '0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= '1;
      addr_q <= '1;
      ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (dly_done) begin
          state_q <= ST_PRE;
          cmd_q   <= CMD_PRECHARGE;
        end
        ST_PRE:  state_q <= ST_TRP;
        ST_TRP: if (dly_done) begin
          state_q    <= ST_AREF;
          cmd_q      <= CMD_AREF;
          aref_cnt_q <= aref_cnt_q + 4'd1;
        end
        ST_AREF: state_q <= ST_TRFC;
        ST_TRFC: if (dly_done) begin
          if (aref_cnt_q == 4'(AREF_NUM)) begin
            state_q <= ST_MRS;
            cmd_q   <= CMD_LOAD_MODE;
            ba_q    <= '0;
            addr_q  <= MRS_ADDR;
          end else begin
            state_q    <= ST_AREF;
            cmd_q      <= CMD_AREF;
            aref_cnt_q <= aref_cnt_q + 4'd1;
          end
        end
        ST_MRS:  state_q <= ST_TMRD;
`ifdef SDRAM_INIT_EMRS_EN
        ST_TMRD: if (dly_done) begin
          state_q <= ST_EMRS;
          cmd_q   <= CMD_LOAD_MODE;
          ba_q    <= BA_W'(2);
          addr_q  <= ADDR_W'(EMRS_VAL);
        end
        ST_EMRS: state_q <= ST_TEMRD;
        ST_TEMRD: if (dly_done) begin
          state_q <= ST_DONE;
          end_q   <= 1'b1;
        end
`else
        ST_TMRD: if (dly_done) begin
          state_q <= ST_DONE;
          end_q   <= 1'b1;
        end
`endif
        ST_DONE: if (reinit_req) begin
          state_q    <= ST_PRE;
          cmd_q      <= CMD_PRECHARGE;
          end_q      <= 1'b0;
          ack_q      <= 1'b1;
          aref_cnt_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign init_cmd   = cmd_q;
  assign init_ba    = ba_q;
  assign init_addr  = addr_q;
  assign init_end   = end_q;
  assign reinit_ack = ack_q;

endmodule

// File: tb/tb_sdram_init_param.sv
// Random reinit/reset stimulus on two configurations, checked against a schedule model.
module tb_sdram_init_param;

  localparam int W    = 100;
  localparam int TRP  = 2;
  localparam int TMRD = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n, reinit_req;
  logic [3:0]  cmd0, cmd1;
  logic [1:0]  ba0, ba1;
  logic [12:0] addr0, addr1;
  logic        end0, end1, ack0, ack1;

  int n_cmp = 0;
  int n_err = 0;
  int pos[2];
  logic eack[2];
  int narf[2] = '{8, 2};
  int trfc[2] = '{7, 4};

  always #5 sys_clk = ~sys_clk;

  sdram_init_param #(.WAIT_CLK(W), .EMRS_VAL(13'h0020)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit_req(reinit_req),
    .init_cmd(cmd0), .init_ba(ba0), .init_addr(addr0), .init_end(end0), .reinit_ack(ack0));

  sdram_init_param #(.WAIT_CLK(W), .AREF_NUM(2), .TRFC_CLK(4), .EMRS_VAL(13'h0020)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit_req(reinit_req),
    .init_cmd(cmd1), .init_ba(ba1), .init_addr(addr1), .init_end(end1), .reinit_ack(ack1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic int seq_len(input int na, input int tr);
    int l;
    l = W + 1 + TRP + na * (1 + tr) + 1 + TMRD;
`ifdef SDRAM_INIT_EMRS_EN
    l += 1 + TMRD;
`endif
    return l;
  endfunction

  // Expected bus at schedule position p (p=0: first edge after reset release).
  function automatic logic [31:0] exp_out(input int p, input int na, input int tr, input logic ack);
    logic [3:0] c; logic [1:0] b; logic [12:0] a; logic ie;
    int per, q, m;
    c = 4'b0111; b = 2'b11; a = 13'h1fff;
    per = 1 + tr;
    q   = p - W - 1 - TRP;
    m   = q - na * per;
    ie  = (p >= seq_len(na, tr));
    if (p == W) c = 4'b0010;
    else if (p > W && q >= 0 && q < na * per) begin
      if (q % per == 0) c = 4'b0001;
    end else if (p > W && m == 0) begin
      c = 4'b0000; b = 2'b00; a = 13'h0037;
    end
`ifdef SDRAM_INIT_EMRS_EN
    else if (p > W && m == 1 + TMRD) begin
      c = 4'b0000; b = 2'b10; a = 13'h0020;
    end
`endif
    return {11'b0, c, b, a, ie, ack};
  endfunction

  task automatic compare_all(input string t0, input string t1);
    check(t0, {11'b0, cmd0, ba0, addr0, end0, ack0}, exp_out(pos[0], narf[0], trfc[0], eack[0]));
    check(t1, {11'b0, cmd1, ba1, addr1, end1, ack1}, exp_out(pos[1], narf[1], trfc[1], eack[1]));
  endtask

  initial begin
    int rst_hold;
    rst_hold   = 0;
    sys_rst_n  = 1'b0;
    reinit_req = 1'b0;
    for (int i = 0; i < 2; i++) begin pos[i] = -1; eack[i] = 1'b0; end
    repeat (3) @(negedge sys_clk);
    compare_all("rst0", "rst1");
    sys_rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge sys_clk);
      if (sys_rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (pos[i] >= seq_len(narf[i], trfc[i]) && reinit_req) begin
            pos[i] = W; eack[i] = 1'b1;
          end else begin
            eack[i] = 1'b0;
            if (pos[i] < seq_len(narf[i], trfc[i])) pos[i]++;
          end
        end
      end
      #1;
      compare_all("cyc0", "cyc1");
      @(negedge sys_clk);
      // Hold req high through the first power-up, then random pulses.
      if (cyc < 400)       reinit_req = 1'b1;
      else if (cyc < 600)  reinit_req = 1'b0;
      else                 reinit_req = ($urandom_range(0, 24) == 0);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) sys_rst_n = 1'b1;
      end else if (cyc == 800 || (cyc > 1200 && $urandom_range(0, 699) == 0)) begin
        sys_rst_n = 1'b0;
        rst_hold  = $urandom_range(1, 10);
        for (int i = 0; i < 2; i++) begin pos[i] = -1; eack[i] = 1'b0; end
        #1;
        compare_all("arst0", "arst1");
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
